// File: rtl/poly_sweep_seq_pkg.sv
// Shared types and default sizing for the polynomial sweep sequencer.
package poly_sweep_seq_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int LATENCY_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_FIN
  } state_t;

endpackage

// File: rtl/sweep_wait_cnt.sv
// Loadable down-counter with terminal-count (zero) flag; times the evaluator latency.
module sweep_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/poly_sweep_seq.sv
// Batch sequencer: sweeps x over an arithmetic range through the start-only
// evaluator, streams each indexed result and tracks the running unsigned max.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; last results and max_out hold
// S_LOAD    | dp_rst pulse to evaluator, x already stable
// S_LAUNCH  | inicio pulse, wait counter loaded with LATENCY-2
// S_WAIT    | LATENCY-1 cycles until resultado is valid
// S_CAPTURE | resultado sampled; advance x/index or finish
// S_FIN     | done pulse, back to idle
module poly_sweep_seq
  import poly_sweep_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_first,
  input  logic [WIDTH-1:0] x_step,
  input  logic [CNT_W-1:0] count,
  output logic             dp_rst,
  output logic             inicio,
  output logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] resultado,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] res_index,
  output logic [WIDTH-1:0] max_out,
  output logic             busy,
  output logic             done
);

  localparam int WC_W = $clog2(LATENCY + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] step_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] index;
  logic             wait_zero;
  logic             last_point;
  logic             accept;

  logic dp_rst_nxt, inicio_nxt, busy_nxt, done_nxt, res_valid_nxt;

  assign accept     = (state == S_IDLE) && start;
  assign last_point = (index == (count_r - 1'b1));

  sweep_wait_cnt #(
    .W(WC_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_LAUNCH),
    .dec     (state == S_WAIT),
    .load_val(WC_W'(LATENCY - 2)),
    .zero    (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (count != '0) ? S_LOAD : S_FIN;
      S_LOAD:    state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT:    if (wait_zero) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = last_point ? S_FIN : S_LOAD;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state and registered so they are glitch-free.
  always_comb begin
    dp_rst_nxt    = (state_nxt == S_LOAD);
    inicio_nxt    = (state_nxt == S_LAUNCH);
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_FIN);
    res_valid_nxt = (state == S_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_rst    <= 1'b0;
      inicio    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      dp_rst    <= dp_rst_nxt;
      inicio    <= inicio_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      res_valid <= res_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      step_r    <= '0;
      count_r   <= '0;
      index     <= '0;
      res_data  <= '0;
      res_index <= '0;
      max_out   <= '0;
    end else begin
      if (accept) begin
        max_out <= '0;
        if (count != '0) begin
          x       <= x_first;
          step_r  <= x_step;
          count_r <= count;
          index   <= '0;
        end
      end
      if (state == S_CAPTURE) begin
        res_data  <= resultado;
        res_index <= index;
        if (resultado > max_out) max_out <= resultado;
        // x only moves on the CAPTURE->LOAD edge; the sum wraps modulo 2^WIDTH.
        if (!last_point) begin
          index <= index + 1'b1;
          x     <= x + step_r;
        end
      end
    end
  end

endmodule
